// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between the PC sequencer (master) and instruction memory (slave).
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner for the unpipelined datapath: fetch, one-instruction commit window,
// next-PC selection, halt handling and a saturating retired-instruction counter.
module pc_sequencer #(
  parameter int unsigned            PC_W     = 32,
  parameter logic [PC_W-1:0]        RESET_PC = '0,
  parameter int unsigned            CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_sequencer_if.master     imem,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               branchsel,
  input  logic               jump,
  input  logic               jump_reg,
  input  logic               halt,
  input  logic [PC_W-1:0]    br_offset,
  input  logic [PC_W-1:0]    jr_target,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus4,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  state_t          state, state_nxt;
  logic            commit;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] rel_target;

  assign commit     = (state == ST_EXEC) && !stall;
  assign pc_plus4   = pc + PC_W'(4);
  assign rel_target = (pc_plus4 + br_offset) & ALIGN_MASK;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: if (imem.imem_ack) state_nxt = ST_EXEC;
      ST_EXEC:  if (!stall) state_nxt = halt ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_RST;
    endcase
  end

  // Outputs decode the state register directly, so an async reset clears them at once.
  always_comb begin
    imem.imem_req = (state == ST_FETCH);
    instr_valid   = (state == ST_EXEC);
    halted        = (state == ST_HALT);
  end

  always_comb begin
    pc_nxt = pc_plus4;
    if (halt) begin
      pc_nxt = pc;
    end else if (jump_reg) begin
      pc_nxt = jr_target & ALIGN_MASK;
    end else if (jump || branchsel) begin
      pc_nxt = rel_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      retired <= '0;
    end else if (commit) begin
      pc <= pc_nxt;
      if (retired != '1) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule
